// File: rtl/rx_chain_model_mc_pkg.sv
// rtl/rx_chain_model_mc_pkg.sv - shared constants and helpers for the RX decimation chain model
package rx_chain_pkg;

    localparam int RX_N_CH       = 2;
    localparam int RX_DATA_W     = 32;
    localparam int RX_RATE_W     = 12;
    localparam int RX_FIFO_DEPTH = 4;

    // IQ word layout: I in the low half, Q in the high half.
    function automatic int iq_half_w(input int data_w);
        return data_w / 2;
    endfunction

    function automatic int iq_i_msb(input int data_w);
        return data_w / 2 - 1;
    endfunction

    function automatic int iq_q_lsb(input int data_w);
        return data_w / 2;
    endfunction

    function automatic int iq_q_msb(input int data_w);
        return data_w - 1;
    endfunction

    // Clip a signed value into the signed range of out_w bits.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/rx_chain_model_mc_if.sv
// rtl/rx_chain_model_mc_if.sv - stream and control bundle of the RX chain model
// master: the stimulus/consumer side; slave: the RX chain itself.
interface rx_chain_model_mc_if
    import rx_chain_pkg::*;
#(
    parameter int N_CH   = RX_N_CH,
    parameter int DATA_W = RX_DATA_W
);
    logic [N_CH*16-1:0]     rate_axis_tdata_i;
    logic [N_CH-1:0]        rate_axis_tvalid_i;
    logic [N_CH*DATA_W-1:0] dds_iq_axis_tdata_i;
    logic [N_CH-1:0]        dds_iq_axis_tvalid_i;
    logic [N_CH-1:0]        axis_tready_i;
    logic [N_CH-1:0]        axis_tvalid_o;
    logic [N_CH*DATA_W-1:0] axis_tdata_o;
    logic [N_CH-1:0]        overflow_o;
    logic [N_CH-1:0]        overflow_clr_i;

    modport master (
        output rate_axis_tdata_i, rate_axis_tvalid_i,
        output dds_iq_axis_tdata_i, dds_iq_axis_tvalid_i,
        output axis_tready_i, overflow_clr_i,
        input  axis_tvalid_o, axis_tdata_o, overflow_o
    );

    modport slave (
        input  rate_axis_tdata_i, rate_axis_tvalid_i,
        input  dds_iq_axis_tdata_i, dds_iq_axis_tvalid_i,
        input  axis_tready_i, overflow_clr_i,
        output axis_tvalid_o, axis_tdata_o, overflow_o
    );
endinterface

// File: rtl/rx_chan_fifo.sv
// rtl/rx_chan_fifo.sv - per-channel synchronous output FIFO
// Ports: push/push_data write side, pop read side, full/empty status,
// head_data is the registered word at the read pointer.
module rx_chan_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              wr_en;
    logic              rd_en;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO is still taken when a pop frees a slot the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/rx_chain_model_mc.sv
// rtl/rx_chain_model_mc.sv - multi-channel RX decimation chain behavioural model
// Ports: clk, rst_n (async active-low); bus (slave modport) carries per-channel
// rate writes, DDS IQ samples, output stream with tready backpressure and the
// sticky overflow flag with its clear.
// Build option RX_CHAIN_ACCUM_EN: boxcar integrate-and-dump instead of
// sample-and-hold decimation.
module rx_chain_model_mc
    import rx_chain_pkg::*;
#(
    parameter int N_CH       = RX_N_CH,
    parameter int DATA_W     = RX_DATA_W,
    parameter int RATE_W     = RX_RATE_W,
    parameter int FIFO_DEPTH = RX_FIFO_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    rx_chain_model_mc_if.slave bus
);
    localparam int HALF_W = iq_half_w(DATA_W);
    localparam int I_MSB  = iq_i_msb(DATA_W);
    localparam int Q_LSB  = iq_q_lsb(DATA_W);
    localparam int Q_MSB  = iq_q_msb(DATA_W);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [15:0]       rate_word;
        logic              rate_we;
        logic [DATA_W-1:0] sample;
        logic              sample_v;
        logic [RATE_W-1:0] rate_q;
        logic [RATE_W-1:0] cnt_q;
        logic              counting;
        logic              tick;
        logic [DATA_W-1:0] tick_word;
        logic              fifo_full;
        logic              fifo_empty;
        logic              pop;
        logic [DATA_W-1:0] head;
        logic              ovf_q;

        assign rate_word = bus.rate_axis_tdata_i[c*16 +: 16];
        assign rate_we   = bus.rate_axis_tvalid_i[c];
        assign sample    = bus.dds_iq_axis_tdata_i[c*DATA_W +: DATA_W];
        assign sample_v  = bus.dds_iq_axis_tvalid_i[c];

        if (RATE_W < 16) begin : g_rate_hi
            logic unused_rate_hi;
            assign unused_rate_hi = ^rate_word[15:RATE_W];
        end

        // A rate write swallows that cycle's sample; rate 0 freezes the counter.
        assign counting = !rate_we && (rate_q != '0) && sample_v;
        assign tick     = counting && (cnt_q == rate_q - RATE_W'(1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rate_q <= '0;
                cnt_q  <= '0;
            end else if (rate_we) begin
                rate_q <= rate_word[RATE_W-1:0];
                cnt_q  <= '0;
            end else if (counting) begin
                cnt_q <= tick ? '0 : cnt_q + RATE_W'(1);
            end
        end

`ifdef RX_CHAIN_ACCUM_EN
        localparam int ACC_W = HALF_W + RATE_W;

        logic signed [ACC_W-1:0] acc_i_q;
        logic signed [ACC_W-1:0] acc_q_q;
        logic signed [ACC_W-1:0] ext_i;
        logic signed [ACC_W-1:0] ext_q;
        logic signed [ACC_W-1:0] sum_i;
        logic signed [ACC_W-1:0] sum_q;

        assign ext_i = {{RATE_W{sample[I_MSB]}}, sample[I_MSB:0]};
        assign ext_q = {{RATE_W{sample[Q_MSB]}}, sample[Q_MSB:Q_LSB]};

        // At window start (cnt 0) the stale accumulator is ignored, so the sum
        // restarts from this sample's own contribution.
        assign sum_i = ((cnt_q == '0) ? '0 : acc_i_q) + ext_i;
        assign sum_q = ((cnt_q == '0) ? '0 : acc_q_q) + ext_q;

        assign tick_word = {HALF_W'(sat_clip(64'(sum_q), HALF_W)),
                            HALF_W'(sat_clip(64'(sum_i), HALF_W))};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else if (rate_we || tick) begin
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else if (counting) begin
                acc_i_q <= sum_i;
                acc_q_q <= sum_q;
            end
        end
`else
        assign tick_word = sample;
`endif

        assign pop = !fifo_empty && bus.axis_tready_i[c];

        rx_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (tick),
            .push_data (tick_word),
            .pop       (pop),
            .full      (fifo_full),
            .empty     (fifo_empty),
            .head_data (head)
        );

        // Set beats clear when both happen on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf_q <= 1'b0;
            end else if (tick && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end else if (bus.overflow_clr_i[c]) begin
                ovf_q <= 1'b0;
            end
        end

        assign bus.axis_tvalid_o[c]                = !fifo_empty;
        assign bus.axis_tdata_o[c*DATA_W +: DATA_W] = head;
        assign bus.overflow_o[c]                   = ovf_q;
    end
endmodule
